// File: rtl/booth_product_sm_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// booth_product_sm_decoder
//
// Converts a signed two's-complement product into sign-magnitude form
// {sign, |P|}. The magnitude is produced STEP bits per clock, LSB first. Each
// bit is copied up to and including the first 1, and inverted after that. The
// "seen a 1" state is held in a flop between chunks. Latency is always
// N = WIDTH/STEP edges from accept to o_valid, including for positive inputs.
//
// Ports
//   i_clk    in   1      clock, rising edge
//   i_rst_n  in   1      asynchronous active-low reset
//   i_valid  in   1      input product valid
//   o_ready  out  1      block can accept a product this cycle
//   i_data   in   WIDTH  two's-complement product
//   o_valid  out  1      result valid, held until accepted
//   i_ready  in   1      downstream accepts result
//   o_sign   out  1      sign of the accepted product
//   o_mag    out  WIDTH  unsigned magnitude |i_data|
//   o_busy   out  1      high while converting
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | empty, ready for a product
// RUN   | converting chunk cnt of the work register
// DONE  | result presented on o_valid/o_sign/o_mag, waiting for i_ready
// -----------------------------------------------------------------------------
module booth_product_sm_decoder #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_busy
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] work_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sign_r;
  logic             seen;
  logic             seen_nxt;
  logic [STEP-1:0]  chunk_in;
  logic [STEP-1:0]  chunk_out;
  logic             seen_run;
  logic             accept;
  logic             last_step;

  assign accept    = i_valid & o_ready;
  assign last_step = (state == S_RUN) && (cnt == CNT_LAST);

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_RUN;
      S_RUN:  if (last_step) state_nxt = S_DONE;
      S_DONE: if (i_ready) state_nxt = i_valid ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    o_ready = (state == S_IDLE) || ((state == S_DONE) && i_ready);
    o_valid = (state == S_DONE);
    o_busy  = (state == S_RUN);
  end

  // One chunk of the copy-then-invert rule. The chunk is rewritten in place in
  // the work register, so after N steps it holds the complete magnitude.
  always_comb begin
    int base;
    base      = int'(cnt) * STEP;
    chunk_in  = work_d[base +: STEP];
    chunk_out = '0;
    seen_run  = seen;
    for (int j = 0; j < STEP; j++) begin
      chunk_out[j] = sign_r ? (chunk_in[j] ^ seen_run) : chunk_in[j];
      seen_run     = seen_run | chunk_in[j];
    end
    seen_nxt = seen_run;
    work_nxt = work_d;
    work_nxt[base +: STEP] = chunk_out;
  end

  // Result registers only load at completion; they hold their last value
  // through handshakes and IDLE, qualified by o_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      work_d <= '0;
      cnt    <= '0;
      sign_r <= 1'b0;
      seen   <= 1'b0;
      o_sign <= 1'b0;
      o_mag  <= '0;
    end else if (accept) begin
      work_d <= i_data;
      sign_r <= i_data[WIDTH-1];
      seen   <= 1'b0;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      work_d <= work_nxt;
      seen   <= seen_nxt;
      cnt    <= cnt + CNT_W'(1);
      if (last_step) begin
        o_mag  <= work_nxt;
        o_sign <= sign_r;
      end
    end
  end

endmodule
